ghost_move_ctrl: RTL and testbench

- Sequences one ghost's position (xGhost, yGhost) on the pixel grid; the ghost display block consumes these outputs.
- Runs a move-tick divider and a chase/frightened/eaten mode machine.
- Selects a direction by querying a shared maze-wall lookup through a req/ack handshake, then steps the ghost by one pixel.

---
 rtl/ghost_move_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_ghost_move_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ghost_move_ctrl.sv
// Ghost motion sequencer: move-tick divider, chase/fright/eaten mode machine and a
// wall-query handshake that picks one of four candidate steps per tick.
module ghost_move_ctrl #(
  parameter int unsigned X_HOME       = 320,
  parameter int unsigned Y_HOME       = 240,
  parameter int unsigned X_MIN        = 1,
  parameter int unsigned X_MAX        = 638,
  parameter int unsigned Y_MIN        = 1,
  parameter int unsigned Y_MAX        = 478,
  parameter int unsigned STEP_DIV     = 400000,
  parameter int unsigned FRIGHT_TICKS = 300
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       e_start,
  input  logic       m_hold,
  input  logic       power_pill,
  input  logic       eaten,
  input  logic [9:0] x_pac,
  input  logic [8:0] y_pac,
  output logic       q_req,
  output logic [9:0] q_x,
  output logic [8:0] q_y,
  input  logic       q_ack,
  input  logic       q_wall,
  output logic [9:0] xGhost,
  output logic [8:0] yGhost,
  output logic       frightened,
  output logic       returning
);

  localparam int unsigned CntW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam int unsigned TmrW = $clog2(FRIGHT_TICKS + 1);

  typedef enum logic [2:0] {StIdle, StWait, StChoose, StCheck, StQuery, StMove} state_e;
  typedef enum logic [1:0] {ModeChase, ModeFright, ModeEaten} mode_e;

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [CntW-1:0]   cnt_q, cnt_d, lim_m1;
  logic [TmrW-1:0]   tmr_q, tmr_d;
  logic              pend_q, pend_d;
  logic [2:0]        k_q, k_d;
  logic [3:0][1:0]   dirs_q, dirs_d;
  logic [9:0]        x_q, x_d, qx_q, qx_d;
  logic [8:0]        y_q, y_d, qy_q, qy_d;

  logic              run, tick, x_pri, x_neg, y_neg, flee, oob;
  logic [10:0]       tx, dx, adx, cx;
  logic [9:0]        ty, dy, ady, cy;
  logic [1:0]        pri, sec, cur_dir;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      mode_q  <= ModeChase;
      cnt_q   <= '0;
      tmr_q   <= '0;
      pend_q  <= 1'b0;
      k_q     <= '0;
      dirs_q  <= '0;
      x_q     <= 10'(X_HOME);
      y_q     <= 9'(Y_HOME);
      qx_q    <= '0;
      qy_q    <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      pend_q  <= pend_d;
      k_q     <= k_d;
      dirs_q  <= dirs_d;
      x_q     <= x_d;
      y_q     <= y_d;
      qx_q    <= qx_d;
      qy_q    <= qy_d;
    end
  end

  always_comb begin
    // Divider: >= catches a count left above the shorter EATEN limit.
    lim_m1 = (mode_q == ModeEaten) ? CntW'(STEP_DIV / 2 - 1) : CntW'(STEP_DIV - 1);
    run    = (state_q != StIdle) && !m_hold;
    tick   = run && (cnt_q >= lim_m1);
    cnt_d  = !run ? cnt_q : (tick ? '0 : cnt_q + 1'b1);

    // Candidate ordering; direction code is {is_y_axis, negative}.
    tx    = (mode_q == ModeEaten) ? 11'(X_HOME) : {1'b0, x_pac};
    ty    = (mode_q == ModeEaten) ? 10'(Y_HOME) : {1'b0, y_pac};
    dx    = tx - {1'b0, x_q};
    dy    = ty - {1'b0, y_q};
    adx   = dx[10] ? (~dx + 11'd1) : dx;
    ady   = dy[9] ? (~dy + 10'd1) : dy;
    x_pri = adx >= {1'b0, ady};
    flee  = (mode_q == ModeFright);
    x_neg = dx[10] ^ flee;
    y_neg = dy[9] ^ flee;
    pri   = x_pri ? {1'b0, x_neg} : {1'b1, y_neg};
    sec   = x_pri ? {1'b1, y_neg} : {1'b0, x_neg};

    cur_dir = dirs_q[k_q[1:0]];
    cx = {1'b0, x_q};
    cy = {1'b0, y_q};
    if (!cur_dir[1]) cx = cur_dir[0] ? cx - 11'd1 : cx + 11'd1;
    else             cy = cur_dir[0] ? cy - 10'd1 : cy + 10'd1;
    oob = (cx < 11'(X_MIN)) || (cx > 11'(X_MAX)) || (cy < 10'(Y_MIN)) || (cy > 10'(Y_MAX));

    state_d = state_q;
    k_d     = k_q;
    dirs_d  = dirs_q;
    x_d     = x_q;
    y_d     = y_q;
    qx_d    = qx_q;
    qy_d    = qy_q;
    unique case (state_q)
      StIdle:   if (e_start) state_d = StWait;
      StWait:   if (tick || pend_q) state_d = StChoose;
      StChoose: begin
        dirs_d  = {pri ^ 2'b01, sec ^ 2'b01, sec, pri};
        k_d     = '0;
        state_d = StCheck;
      end
      StCheck: begin
        if (k_q == 3'd4) begin
          state_d = StWait;
        end else if (oob) begin
          k_d = k_q + 3'd1;
        end else begin
          qx_d    = cx[9:0];
          qy_d    = cy[8:0];
          state_d = StQuery;
        end
      end
      StQuery: begin
        if (q_ack) begin
          if (q_wall) begin
            k_d     = k_q + 3'd1;
            state_d = StCheck;
          end else begin
            state_d = StMove;
          end
        end
      end
      StMove: begin
        x_d = cx[9:0];
        y_d = cy[8:0];
        // A tick landing here would be lost; chain straight into the next choice.
        state_d = (tick || pend_q) ? StChoose : StWait;
      end
      default: state_d = StIdle;
    endcase

    if ((state_q == StWait || state_q == StMove) && state_d == StChoose) pend_d = 1'b0;
    else                                                              pend_d = pend_q | tick;

    mode_d = mode_q;
    tmr_d  = tmr_q;
    unique case (mode_q)
      ModeChase: begin
        if (power_pill) begin
          mode_d = ModeFright;
          tmr_d  = TmrW'(FRIGHT_TICKS);
        end
      end
      ModeFright: begin
        if (eaten) begin
          mode_d = ModeEaten;
          tmr_d  = '0;
        end else if (power_pill) begin
          tmr_d = TmrW'(FRIGHT_TICKS);
        end else if (tick) begin
          if (tmr_q <= TmrW'(1)) begin
            mode_d = ModeChase;
            tmr_d  = '0;
          end else begin
            tmr_d = tmr_q - 1'b1;
          end
        end
      end
      ModeEaten: begin
        if (state_q == StMove && cx == 11'(X_HOME) && cy == 10'(Y_HOME)) mode_d = ModeChase;
      end
      default: mode_d = ModeChase;
    endcase
  end

  always_comb begin
    q_req      = (state_q == StQuery);
    q_x        = qx_q;
    q_y        = qy_q;
    xGhost     = x_q;
    yGhost     = y_q;
    frightened = (mode_q == ModeFright);
    returning  = (mode_q == ModeEaten);
  end

endmodule

// File: tb/tb_ghost_move_ctrl.sv
// Directed bench for ghost_move_ctrl: fast divider, narrow right edge, scripted wall map.
module tb_ghost_move_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, e_start, m_hold, power_pill, eaten;
  logic [9:0] x_pac;
  logic [8:0] y_pac;
  logic       q_req, q_ack, q_wall, frightened, returning;
  logic [9:0] q_x, xg;
  logic [8:0] q_y, yg;
  logic       ack_en;
  logic [18:0] walls [4];
  int         n_walls;
  logic [18:0] qlog [$];
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  ghost_move_ctrl #(
    .X_MAX       (322),
    .STEP_DIV    (8),
    .FRIGHT_TICKS(3)
  ) dut (
    .clk       (clk),
    .reset     (rst_n),
    .e_start   (e_start),
    .m_hold    (m_hold),
    .power_pill(power_pill),
    .eaten     (eaten),
    .x_pac     (x_pac),
    .y_pac     (y_pac),
    .q_req     (q_req),
    .q_x       (q_x),
    .q_y       (q_y),
    .q_ack     (q_ack),
    .q_wall    (q_wall),
    .xGhost    (xg),
    .yGhost    (yg),
    .frightened(frightened),
    .returning (returning)
  );

  assign q_ack = q_req & ack_en;

  always_comb begin
    q_wall = 1'b0;
    for (int i = 0; i < 4; i++) if (i < n_walls && walls[i] == {q_x, q_y}) q_wall = 1'b1;
  end

  always @(posedge clk) if (q_req && q_ack) qlog.push_back({q_x, q_y});

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; e_start = 1'b0; m_hold = 1'b0; power_pill = 1'b0; eaten = 1'b0;
    ack_en = 1'b1; n_walls = 0; x_pac = 10'd330; y_pac = 9'd240;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    qlog.delete();
  endtask

  task automatic wait_xy(input logic [9:0] x, input logic [8:0] y, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (xg == x && yg == y) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; e_start = 1'b0; m_hold = 1'b0; power_pill = 1'b0; eaten = 1'b0;
    ack_en = 1'b1; n_walls = 0; x_pac = 10'd330; y_pac = 9'd240;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({q_req, q_x, q_y, frightened, returning} !== 22'd0) begin
      n_err++;
      $display("FAIL reset_outs: req=%b qx=%0d qy=%0d fr=%b ret=%b, want all 0",
               q_req, q_x, q_y, frightened, returning);
    end
    n_vec++;
    if (xg !== 10'd320 || yg !== 9'd240) begin
      n_err++;
      $display("FAIL reset_pos: got (%0d,%0d) want (320,240)", xg, yg);
    end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    n_vec++;
    if (q_req !== 1'b0 || xg !== 10'd320 || yg !== 9'd240) begin
      n_err++;
      $display("FAIL idle_hold: req=%b pos (%0d,%0d) want 0 (320,240)", q_req, xg, yg);
    end
  endtask

  task automatic test_reset_mid_query();
    bit seen = 1'b0;
    do_reset();
    ack_en = 1'b0;
    e_start = 1'b1;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      seen = q_req;
    end
    n_vec++;
    if (!seen || q_x !== 10'd321 || q_y !== 9'd240) begin
      n_err++;
      $display("FAIL midq_req: req=%b q=(%0d,%0d) want 1 (321,240)", q_req, q_x, q_y);
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (q_req !== 1'b1 || q_x !== 10'd321 || q_y !== 9'd240) begin
      n_err++;
      $display("FAIL midq_hold: req=%b q=(%0d,%0d) want 1 (321,240)", q_req, q_x, q_y);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (q_req !== 1'b0 || xg !== 10'd320 || yg !== 9'd240 || frightened !== 1'b0) begin
      n_err++;
      $display("FAIL midq_reset: req=%b pos (%0d,%0d) fr=%b want 0 (320,240) 0",
               q_req, xg, yg, frightened);
    end
    @(negedge clk);
    e_start = 1'b0;
    ack_en = 1'b1;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    n_vec++;
    if (q_req !== 1'b0 || xg !== 10'd320 || yg !== 9'd240 || qlog.size() != 0) begin
      n_err++;
      $display("FAIL midq_idle: req=%b pos (%0d,%0d) queries=%0d want 0 (320,240) 0",
               q_req, xg, yg, qlog.size());
    end
  endtask

  task automatic test_chase();
    bit  ok;
    time t0;
    do_reset();
    e_start = 1'b1;
    wait_xy(10'd321, 9'd240, 40, ok);
    t0 = $time;
    n_vec++;
    if (!ok || qlog.size() != 1 || qlog[0] !== {10'd321, 9'd240}) begin
      n_err++;
      $display("FAIL chase_first: pos (%0d,%0d) queries=%0d want (321,240) 1", xg, yg,
               qlog.size());
    end
    wait_xy(10'd322, 9'd240, 20, ok);
    n_vec++;
    if (!ok || ($time - t0) != 80) begin
      n_err++;
      $display("FAIL chase_rate: reached=%b interval=%0t want 1 80", ok, $time - t0);
    end
    // Right of 322 is off-grid, so the next step must go down without querying 323.
    wait_xy(10'd322, 9'd241, 20, ok);
    n_vec++;
    if (!ok || qlog.size() != 3 || qlog[2] !== {10'd322, 9'd241}) begin
      n_err++;
      $display("FAIL chase_edge: reached=%b queries=%0d last=%h want 1 3 %h", ok,
               qlog.size(), (qlog.size() > 0) ? qlog[qlog.size()-1] : 19'd0,
               {10'd322, 9'd241});
    end
  endtask

  task automatic test_walls();
    bit ok;
    do_reset();
    walls[0] = {10'd321, 9'd240};
    walls[1] = {10'd320, 9'd241};
    n_walls = 2;
    e_start = 1'b1;
    wait_xy(10'd320, 9'd239, 40, ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL walls_move: pos (%0d,%0d) want (320,239)", xg, yg);
    end
    n_vec++;
    if (qlog.size() != 3 || qlog[0] !== {10'd321, 9'd240} || qlog[1] !== {10'd320, 9'd241}
        || qlog[2] !== {10'd320, 9'd239}) begin
      n_err++;
      $display("FAIL walls_order: queries=%0d want 3 in order (321,240)(320,241)(320,239)",
               qlog.size());
    end
  endtask

  task automatic test_all_walls();
    bit ok = 1'b0;
    do_reset();
    walls[0] = {10'd321, 9'd240};
    walls[1] = {10'd319, 9'd240};
    walls[2] = {10'd320, 9'd241};
    walls[3] = {10'd320, 9'd239};
    n_walls = 4;
    e_start = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = (qlog.size() >= 4);
    end
    repeat (2) @(negedge clk);
    n_vec++;
    if (!ok || qlog.size() != 4 || q_req !== 1'b0) begin
      n_err++;
      $display("FAIL boxed_count: queries=%0d req=%b want 4 0", qlog.size(), q_req);
    end
    n_vec++;
    if (xg !== 10'd320 || yg !== 9'd240) begin
      n_err++;
      $display("FAIL boxed_pos: got (%0d,%0d) want (320,240)", xg, yg);
    end
    n_vec++;
    if (qlog.size() < 4 || qlog[0] !== {10'd321, 9'd240} || qlog[1] !== {10'd320, 9'd241}
        || qlog[2] !== {10'd320, 9'd239} || qlog[3] !== {10'd319, 9'd240}) begin
      n_err++;
      $display("FAIL boxed_order: queries=%0d want R,D,U,L order", qlog.size());
    end
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      ok = (qlog.size() >= 5);
    end
    n_vec++;
    if (!ok || qlog[4] !== {10'd321, 9'd240}) begin
      n_err++;
      $display("FAIL boxed_retry: queries=%0d want a fresh (321,240) query", qlog.size());
    end
  endtask

  task automatic test_fright();
    bit ok;
    do_reset();
    e_start = 1'b1;
    @(negedge clk);
    power_pill = 1'b1;
    @(negedge clk);
    power_pill = 1'b0;
    n_vec++;
    if (frightened !== 1'b1 || returning !== 1'b0) begin
      n_err++;
      $display("FAIL fright_on: fr=%b ret=%b want 1 0", frightened, returning);
    end
    wait_xy(10'd319, 9'd240, 40, ok);
    n_vec++;
    if (!ok || qlog.size() < 1 || qlog[0] !== {10'd319, 9'd240} || frightened !== 1'b1) begin
      n_err++;
      $display("FAIL fright_flee: pos (%0d,%0d) fr=%b want (319,240) 1", xg, yg, frightened);
    end
    wait_xy(10'd318, 9'd240, 20, ok);
    n_vec++;
    if (!ok || frightened !== 1'b1) begin
      n_err++;
      $display("FAIL fright_tick2: pos (%0d,%0d) fr=%b want (318,240) 1", xg, yg, frightened);
    end
    wait_xy(10'd319, 9'd240, 20, ok);
    n_vec++;
    if (!ok || frightened !== 1'b0) begin
      n_err++;
      $display("FAIL fright_expire: pos (%0d,%0d) fr=%b want (319,240) 0", xg, yg, frightened);
    end
  endtask

  task automatic test_eaten_hold();
    bit  ok;
    time t0;
    do_reset();
    e_start = 1'b1;
    @(negedge clk);
    power_pill = 1'b1;
    @(negedge clk);
    power_pill = 1'b0;
    wait_xy(10'd319, 9'd240, 40, ok);
    m_hold = 1'b1;
    repeat (40) @(negedge clk);
    n_vec++;
    if (!ok || xg !== 10'd319 || frightened !== 1'b1 || qlog.size() != 1) begin
      n_err++;
      $display("FAIL hold_freeze: x=%0d fr=%b queries=%0d want 319 1 1", xg, frightened,
               qlog.size());
    end
    m_hold = 1'b0;
    wait_xy(10'd318, 9'd240, 20, ok);
    n_vec++;
    if (!ok || frightened !== 1'b1) begin
      n_err++;
      $display("FAIL hold_resume: x=%0d fr=%b want 318 1", xg, frightened);
    end
    eaten = 1'b1;
    @(negedge clk);
    eaten = 1'b0;
    n_vec++;
    if (returning !== 1'b1 || frightened !== 1'b0) begin
      n_err++;
      $display("FAIL eaten_on: ret=%b fr=%b want 1 0", returning, frightened);
    end
    wait_xy(10'd319, 9'd240, 20, ok);
    t0 = $time;
    wait_xy(10'd320, 9'd240, 20, ok);
    n_vec++;
    if (!ok || ($time - t0) != 40) begin
      n_err++;
      $display("FAIL eaten_rate: reached=%b interval=%0t want 1 40", ok, $time - t0);
    end
    @(negedge clk);
    n_vec++;
    if (returning !== 1'b0 || frightened !== 1'b0) begin
      n_err++;
      $display("FAIL eaten_home: ret=%b fr=%b want 0 0", returning, frightened);
    end
    eaten = 1'b1;
    @(negedge clk);
    eaten = 1'b0;
    @(negedge clk);
    n_vec++;
    if (returning !== 1'b0) begin
      n_err++;
      $display("FAIL chase_eaten: ret=%b want 0", returning);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_query();
    test_chase();
    test_walls();
    test_all_walls();
    test_fright();
    test_eaten_hold();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
